// File: rtl/aq_ifu_bht_pkg.sv
// Shared types and constants for the IFU BHT write buffer.
// Used by aq_ifu_bht_wbuf (optional AQ_IFU_BHT_WBUF_FWD_EN build) and its FIFO.
package aq_ifu_bht_pkg;

    localparam int BHT_IDX_W      = 10;
    localparam int BHT_DATA_W     = 16;
    localparam int BHT_WBUF_DEPTH = 4;
    localparam int BHT_PTR_W      = 2;
    localparam int BHT_SEL_W      = 3;
    localparam int BHT_CNT_W      = 2;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bht_cnt_e;

    typedef struct packed {
        logic [BHT_IDX_W-1:0] idx;
        logic [BHT_SEL_W-1:0] sel;
        logic [BHT_CNT_W-1:0] cnt;
    } bht_wbuf_entry_t;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [BHT_CNT_W-1:0] bht_cnt_next(
        input logic [BHT_CNT_W-1:0] cnt,
        input logic                 taken
    );
        if (taken) begin
            return (cnt == 2'(ST)) ? 2'(ST) : cnt + 2'd1;
        end else begin
            return (cnt == 2'(SNT)) ? 2'(SNT) : cnt - 2'd1;
        end
    endfunction

endpackage

// File: rtl/aq_ifu_bht_wbuf_fifo.sv
// In-order 4-entry update FIFO; pointers carry a wrap bit to tell full from empty.
// With AQ_IFU_BHT_WBUF_FWD_EN defined it also exposes entries, valids and head pointer.
module aq_ifu_bht_wbuf_fifo
    import aq_ifu_bht_pkg::*;
(
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_clr,
    input  logic                                   i_push,
    input  bht_wbuf_entry_t                        i_push_entry,
    input  logic                                   i_pop,
    output bht_wbuf_entry_t                        o_head,
    output logic                                   o_full,
    output logic                                   o_empty
`ifdef AQ_IFU_BHT_WBUF_FWD_EN
    ,
    output bht_wbuf_entry_t [BHT_WBUF_DEPTH-1:0]   o_entries,
    output logic [BHT_WBUF_DEPTH-1:0]              o_vld,
    output logic [BHT_PTR_W-1:0]                   o_rd_ptr
`endif
);

    logic [BHT_PTR_W:0] r_wr_ptr;
    logic [BHT_PTR_W:0] r_rd_ptr;
    logic [BHT_PTR_W:0] w_count;
    bht_wbuf_entry_t    r_mem [BHT_WBUF_DEPTH];

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_full  = (w_count == (BHT_PTR_W+1)'(BHT_WBUF_DEPTH));
    assign o_empty = (w_count == '0);
    assign o_head  = r_mem[r_rd_ptr[BHT_PTR_W-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; validity lives in the pointers.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[BHT_PTR_W-1:0]] <= i_push_entry;
        end
    end

`ifdef AQ_IFU_BHT_WBUF_FWD_EN
    logic [BHT_WBUF_DEPTH-1:0] r_vld;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_vld <= '0;
        end else begin
            if (i_pop) begin
                r_vld[r_rd_ptr[BHT_PTR_W-1:0]] <= 1'b0;
            end
            if (i_push) begin
                r_vld[r_wr_ptr[BHT_PTR_W-1:0]] <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < BHT_WBUF_DEPTH; i++) begin
            o_entries[i] = r_mem[i];
        end
    end

    assign o_vld    = r_vld;
    assign o_rd_ptr = r_rd_ptr[BHT_PTR_W-1:0];
`endif

endmodule

// File: rtl/aq_ifu_bht_wbuf.sv
// BHT write buffer: queues branch-resolve counter updates and arbitrates them against
// prediction reads. Define AQ_IFU_BHT_WBUF_FWD_EN to forward pending updates into read data.
module aq_ifu_bht_wbuf
    import aq_ifu_bht_pkg::*;
(
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  cp0_ifu_bht_en,
    input  logic                  ifu_bht_rd_req,
    input  logic [BHT_IDX_W-1:0]  ifu_bht_rd_idx,
    output logic                  bht_ifu_rd_gnt,
    output logic                  bht_ifu_rd_vld,
    output logic [BHT_DATA_W-1:0] bht_ifu_rd_data,
    input  logic                  upd_vld,
    input  logic [BHT_IDX_W-1:0]  upd_idx,
    input  logic [BHT_SEL_W-1:0]  upd_sel,
    input  logic [BHT_CNT_W-1:0]  upd_cnt,
    input  logic                  upd_taken,
    output logic                  upd_rdy,
    output logic                  bht_cen,
    output logic                  bht_cen_gate,
    output logic [BHT_IDX_W-1:0]  bht_idx,
    output logic [BHT_DATA_W-1:0] bht_din,
    output logic [BHT_DATA_W-1:0] bht_wen,
    input  logic [BHT_DATA_W-1:0] bht_dout,
    output logic                  wbuf_empty
);

    logic                  w_en;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_push;
    bht_wbuf_entry_t       w_head;
    bht_wbuf_entry_t       w_push_entry;
    logic [BHT_DATA_W-1:0] w_fwd_data;
    logic                  r_rd_vld;

    assign w_en = cp0_ifu_bht_en & ~cpurst;

    // Update handshake: an update transfers on a cycle where upd_vld and upd_rdy are both
    // high; upd_rdy depends only on registered fullness, never on upd_vld or a same-cycle pop.
    assign upd_rdy      = w_en & ~w_full;
    assign w_push       = upd_vld & upd_rdy;
    assign w_push_entry = '{idx: upd_idx, sel: upd_sel, cnt: bht_cnt_next(upd_cnt, upd_taken)};

    // Reads win unless the buffer is full, which forces a drain so updates cannot starve.
    assign w_rd = w_en & ifu_bht_rd_req & ~w_full;
    assign w_wr = w_en & ~w_rd & ~w_empty;

    assign bht_ifu_rd_gnt = w_rd;
    assign bht_cen        = w_rd | w_wr;
    assign bht_cen_gate   = (ifu_bht_rd_req | ~w_empty) & w_en;
    assign wbuf_empty     = w_empty;

    always_comb begin
        bht_idx = '0;
        bht_din = '0;
        bht_wen = '0;
        if (w_rd) begin
            bht_idx = ifu_bht_rd_idx;
        end else if (w_wr) begin
            bht_idx = w_head.idx;
            bht_din = {(BHT_DATA_W/BHT_CNT_W){w_head.cnt}};
            bht_wen = BHT_DATA_W'(2'b11) << {w_head.sel, 1'b0};
        end
    end

`ifdef AQ_IFU_BHT_WBUF_FWD_EN
    bht_wbuf_entry_t [BHT_WBUF_DEPTH-1:0] w_entries;
    logic [BHT_WBUF_DEPTH-1:0]            w_vld;
    logic [BHT_PTR_W-1:0]                 w_rd_ptr;
    logic [BHT_PTR_W-1:0]                 w_slot;
    logic [BHT_IDX_W-1:0]                 r_rd_idx;
`endif

    aq_ifu_bht_wbuf_fifo u_fifo (
        .i_clk        (forever_cpuclk),
        .i_rst        (cpurst),
        .i_clr        (~cp0_ifu_bht_en),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_wr),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty)
`ifdef AQ_IFU_BHT_WBUF_FWD_EN
        ,
        .o_entries    (w_entries),
        .o_vld        (w_vld),
        .o_rd_ptr     (w_rd_ptr)
`endif
    );

    // The response is not gated by the enable: a granted read always completes.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_rd;
        end
    end

`ifdef AQ_IFU_BHT_WBUF_FWD_EN
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_rd_idx <= '0;
        end else if (w_rd) begin
            r_rd_idx <= ifu_bht_rd_idx;
        end
    end

    // Walk oldest to youngest so the most recent matching update owns its slot.
    always_comb begin
        w_fwd_data = bht_dout;
        w_slot     = '0;
        for (int i = 0; i < BHT_WBUF_DEPTH; i++) begin
            w_slot = w_rd_ptr + BHT_PTR_W'(i);
            if (w_vld[w_slot] && (w_entries[w_slot].idx == r_rd_idx)) begin
                w_fwd_data[{w_entries[w_slot].sel, 1'b0} +: BHT_CNT_W] = w_entries[w_slot].cnt;
            end
        end
    end
`else
    assign w_fwd_data = bht_dout;
`endif

    assign bht_ifu_rd_vld  = r_rd_vld & ~cpurst;
    assign bht_ifu_rd_data = bht_ifu_rd_vld ? w_fwd_data : '0;

endmodule

// File: tb/tb_aq_ifu_bht_wbuf.sv
// Self-checking bench for aq_ifu_bht_wbuf; expectations follow AQ_IFU_BHT_WBUF_FWD_EN when defined.
module tb_aq_ifu_bht_wbuf;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst = 1'b1;
  logic        cp0_ifu_bht_en = 1'b1;
  logic        ifu_bht_rd_req = 1'b0;
  logic [9:0]  ifu_bht_rd_idx = '0;
  logic        bht_ifu_rd_gnt;
  logic        bht_ifu_rd_vld;
  logic [15:0] bht_ifu_rd_data;
  logic        upd_vld = 1'b0;
  logic [9:0]  upd_idx = '0;
  logic [2:0]  upd_sel = '0;
  logic [1:0]  upd_cnt = '0;
  logic        upd_taken = 1'b0;
  logic        upd_rdy;
  logic        bht_cen;
  logic        bht_cen_gate;
  logic [9:0]  bht_idx;
  logic [15:0] bht_din;
  logic [15:0] bht_wen;
  logic [15:0] bht_dout = '0;
  logic        wbuf_empty;

  int n_checks = 0;
  int n_fail = 0;

  aq_ifu_bht_wbuf dut (
    .forever_cpuclk  (forever_cpuclk),
    .cpurst          (cpurst),
    .cp0_ifu_bht_en  (cp0_ifu_bht_en),
    .ifu_bht_rd_req  (ifu_bht_rd_req),
    .ifu_bht_rd_idx  (ifu_bht_rd_idx),
    .bht_ifu_rd_gnt  (bht_ifu_rd_gnt),
    .bht_ifu_rd_vld  (bht_ifu_rd_vld),
    .bht_ifu_rd_data (bht_ifu_rd_data),
    .upd_vld         (upd_vld),
    .upd_idx         (upd_idx),
    .upd_sel         (upd_sel),
    .upd_cnt         (upd_cnt),
    .upd_taken       (upd_taken),
    .upd_rdy         (upd_rdy),
    .bht_cen         (bht_cen),
    .bht_cen_gate    (bht_cen_gate),
    .bht_idx         (bht_idx),
    .bht_din         (bht_din),
    .bht_wen         (bht_wen),
    .bht_dout        (bht_dout),
    .wbuf_empty      (wbuf_empty)
  );

  // clock
  always #5 forever_cpuclk = ~forever_cpuclk;

  // reference model: pending updates in arrival order
  typedef struct packed {
    logic [9:0] idx;
    logic [2:0] sel;
    logic [1:0] cnt;
  } m_ent_t;

  m_ent_t      mq[$];
  logic [41:0] exp_q[$];
  logic        m_prev_gnt = 1'b0;
  logic [9:0]  m_prev_idx = '0;
  bit          m_pending = 1'b0;

  logic        e_rdy, e_gnt, e_cen, e_gate, e_vld, e_empty, e_write, e_chk_empty;
  logic [9:0]  e_idx;
  logic [15:0] e_din, e_wen, e_data;

  function automatic logic [1:0] ref_next(input logic [1:0] c, input logic t);
    int v;
    v = t ? int'(c) + 1 : int'(c) - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic model_eval();
    int n;
    logic [15:0] d;
    n = mq.size();
    e_chk_empty = !cpurst;
    e_empty = (n == 0);
    e_write = 0; e_rdy = 0; e_gnt = 0; e_cen = 0; e_gate = 0;
    e_wen = '0; e_idx = '0; e_din = '0; e_vld = 0; e_data = '0;
    if (!cpurst) begin
      e_vld = m_prev_gnt;
      if (m_prev_gnt) begin
        d = bht_dout;
`ifdef AQ_IFU_BHT_WBUF_FWD_EN
        foreach (mq[i]) begin
          if (mq[i].idx == m_prev_idx) d[2*int'(mq[i].sel) +: 2] = mq[i].cnt;
        end
`endif
        e_data = d;
      end
      if (cp0_ifu_bht_en) begin
        e_rdy = (n < 4);
        e_gate = ifu_bht_rd_req || (n > 0);
        if (ifu_bht_rd_req && n < 4) begin
          e_gnt = 1; e_cen = 1; e_idx = ifu_bht_rd_idx;
        end else if (n > 0) begin
          e_write = 1; e_cen = 1;
          e_idx = mq[0].idx;
          e_din = {8{mq[0].cnt}};
          e_wen = 16'h0003 << (2*int'(mq[0].sel));
          exp_q.push_back({e_idx, e_din, e_wen});
        end
      end
    end
  endtask

  task automatic model_commit();
    if (cpurst || !cp0_ifu_bht_en) begin
      mq.delete();
      m_prev_gnt = 0;
    end else begin
      if (e_write) void'(mq.pop_front());
      if (upd_vld && e_rdy) mq.push_back('{upd_idx, upd_sel, ref_next(upd_cnt, upd_taken)});
      m_prev_gnt = e_gnt;
      m_prev_idx = ifu_bht_rd_idx;
    end
  endtask

  // driver: one cycle of inputs, outputs settle before the next rising edge
  task automatic apply(input logic rst, input logic en, input logic rq, input logic [9:0] ridx,
                       input logic uv, input logic [9:0] ui, input logic [2:0] us,
                       input logic [1:0] uc, input logic ut, input logic [15:0] dout);
    if (m_pending) model_commit();
    @(negedge forever_cpuclk);
    cpurst = rst; cp0_ifu_bht_en = en;
    ifu_bht_rd_req = rq; ifu_bht_rd_idx = ridx;
    upd_vld = uv; upd_idx = ui; upd_sel = us; upd_cnt = uc; upd_taken = ut;
    bht_dout = dout;
    #1;
    model_eval();
    m_pending = 1;
  endtask

  task automatic idle();
    apply(0, 1, 0, 10'd0, 0, 10'd0, 3'd0, 2'd0, 0, 16'h0);
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && mq.size() > 0; k++) idle();
    idle();
    n_checks++;
    if (wbuf_empty !== 1'b1) begin
      n_fail++; $display("FAIL drain_empty: got %0b want 1", wbuf_empty);
    end
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 10'd5, 1, 10'd1, 3'd1, 2'd1, 1, 16'hAAAA);
    apply(1, 1, 1, 10'd5, 1, 10'd1, 3'd1, 2'd1, 1, 16'hAAAA);
    n_checks++; if (bht_cen !== 1'b0) begin n_fail++; $display("FAIL reset_cen: got %0b want 0", bht_cen); end
    n_checks++; if (bht_cen_gate !== 1'b0) begin n_fail++; $display("FAIL reset_gate: got %0b want 0", bht_cen_gate); end
    n_checks++; if (bht_wen !== 16'h0) begin n_fail++; $display("FAIL reset_wen: got %h want 0000", bht_wen); end
    n_checks++; if (upd_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %0b want 0", upd_rdy); end
    n_checks++; if (bht_ifu_rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0000", bht_ifu_rd_data); end
    idle();
    n_checks++; if (wbuf_empty !== 1'b1) begin n_fail++; $display("FAIL post_reset_empty: got %0b want 1", wbuf_empty); end
    n_checks++; if (bht_ifu_rd_vld !== 1'b0) begin n_fail++; $display("FAIL post_reset_vld: got %0b want 0", bht_ifu_rd_vld); end
    n_checks++; if (upd_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_rdy: got %0b want 1", upd_rdy); end
  endtask

  task automatic test_single_write();
    apply(0, 1, 0, 10'd0, 1, 10'h3A, 3'd5, 2'd2, 1, 16'h0);
    idle();
    n_checks++; if (bht_cen !== 1'b1) begin n_fail++; $display("FAIL wr_cen: got %0b want 1", bht_cen); end
    n_checks++; if (bht_idx !== 10'h3A) begin n_fail++; $display("FAIL wr_idx: got %h want 03a", bht_idx); end
    n_checks++; if (bht_wen !== 16'h0C00) begin n_fail++; $display("FAIL wr_wen: got %h want 0c00", bht_wen); end
    n_checks++; if (bht_din !== 16'hFFFF) begin n_fail++; $display("FAIL wr_din: got %h want ffff", bht_din); end
    drain();
  endtask

  task automatic test_saturate();
    apply(0, 1, 0, 10'd0, 1, 10'h011, 3'd0, 2'd3, 1, 16'h0);
    idle();
    n_checks++; if (bht_din !== 16'hFFFF) begin n_fail++; $display("FAIL sat_up_din: got %h want ffff", bht_din); end
    n_checks++; if (bht_wen !== 16'h0003) begin n_fail++; $display("FAIL sat_up_wen: got %h want 0003", bht_wen); end
    apply(0, 1, 0, 10'd0, 1, 10'h012, 3'd7, 2'd0, 0, 16'h0);
    idle();
    n_checks++; if (bht_din !== 16'h0000) begin n_fail++; $display("FAIL sat_dn_din: got %h want 0000", bht_din); end
    n_checks++; if (bht_wen !== 16'hC000) begin n_fail++; $display("FAIL sat_dn_wen: got %h want c000", bht_wen); end
    drain();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      apply(0, 1, 1, 10'd9, 1, 10'h100 + 10'(k), 3'd2, 2'd1, 0, 16'h0);
      n_checks++; if (upd_rdy !== 1'b1 || bht_ifu_rd_gnt !== 1'b1) begin
        n_fail++; $display("FAIL fill_%0d: rdy %0b gnt %0b want 1 1", k, upd_rdy, bht_ifu_rd_gnt);
      end
    end
    apply(0, 1, 1, 10'd9, 1, 10'h1FF, 3'd1, 2'd2, 1, 16'h0);
    n_checks++; if (upd_rdy !== 1'b0) begin n_fail++; $display("FAIL full_rdy: got %0b want 0", upd_rdy); end
    n_checks++; if (bht_ifu_rd_gnt !== 1'b0) begin n_fail++; $display("FAIL full_gnt: got %0b want 0", bht_ifu_rd_gnt); end
    n_checks++; if (bht_cen !== 1'b1 || bht_idx !== 10'h100 || bht_wen !== 16'h0030 || bht_din !== 16'h0000) begin
      n_fail++; $display("FAIL full_write: cen %0b idx %h wen %h din %h want 1 100 0030 0000", bht_cen, bht_idx, bht_wen, bht_din);
    end
    apply(0, 1, 1, 10'd9, 1, 10'h1FF, 3'd1, 2'd2, 1, 16'h0);
    n_checks++; if (bht_ifu_rd_gnt !== 1'b1 || upd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL after_full: gnt %0b rdy %0b want 1 1", bht_ifu_rd_gnt, upd_rdy);
    end
    drain();
  endtask

  task automatic test_forward();
    apply(0, 1, 0, 10'd0, 1, 10'd7, 3'd0, 2'd2, 1, 16'h0);
    apply(0, 1, 1, 10'd7, 0, 10'd0, 3'd0, 2'd0, 0, 16'h0);
    n_checks++; if (bht_ifu_rd_gnt !== 1'b1) begin n_fail++; $display("FAIL fwd_gnt: got %0b want 1", bht_ifu_rd_gnt); end
    idle();
    n_checks++; if (bht_ifu_rd_vld !== 1'b1) begin n_fail++; $display("FAIL fwd_vld: got %0b want 1", bht_ifu_rd_vld); end
`ifdef AQ_IFU_BHT_WBUF_FWD_EN
    n_checks++; if (bht_ifu_rd_data !== 16'h0003) begin n_fail++; $display("FAIL fwd_data: got %h want 0003", bht_ifu_rd_data); end
`else
    n_checks++; if (bht_ifu_rd_data !== 16'h0000) begin n_fail++; $display("FAIL fwd_data: got %h want 0000", bht_ifu_rd_data); end
`endif
    drain();
  endtask

  task automatic test_disable();
    for (int k = 0; k < 3; k++) apply(0, 1, 1, 10'd3, 1, 10'd20 + 10'(k), 3'(k), 2'd1, 1, 16'h0);
    apply(0, 0, 0, 10'd0, 1, 10'd30, 3'd0, 2'd0, 0, 16'h1234);
    n_checks++; if (bht_cen !== 1'b0 || bht_wen !== 16'h0) begin n_fail++; $display("FAIL dis_write: cen %0b wen %h want 0 0000", bht_cen, bht_wen); end
    n_checks++; if (upd_rdy !== 1'b0 || bht_ifu_rd_gnt !== 1'b0) begin n_fail++; $display("FAIL dis_hs: rdy %0b gnt %0b want 0 0", upd_rdy, bht_ifu_rd_gnt); end
    n_checks++; if (bht_ifu_rd_vld !== 1'b1) begin n_fail++; $display("FAIL dis_inflight: got %0b want 1", bht_ifu_rd_vld); end
    idle();
    n_checks++; if (wbuf_empty !== 1'b1 || bht_cen !== 1'b0) begin n_fail++; $display("FAIL dis_cleared: empty %0b cen %0b want 1 0", wbuf_empty, bht_cen); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) apply(0, 1, 1, 10'd4, 1, 10'd40 + 10'(k), 3'd3, 2'd2, 0, 16'h0);
    apply(1, 1, 1, 10'd4, 0, 10'd0, 3'd0, 2'd0, 0, 16'hBEEF);
    n_checks++; if (bht_cen !== 1'b0 || bht_ifu_rd_vld !== 1'b0) begin n_fail++; $display("FAIL rst_mid: cen %0b vld %0b want 0 0", bht_cen, bht_ifu_rd_vld); end
    idle();
    n_checks++; if (wbuf_empty !== 1'b1 || bht_cen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: empty %0b cen %0b want 1 0", wbuf_empty, bht_cen); end
    for (int k = 0; k < 3; k++) begin
      idle();
      n_checks++; if (bht_cen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_nowrite_%0d: cen %0b want 0", k, bht_cen); end
    end
  endtask

  task automatic test_random();
    logic [41:0] got;
    logic [41:0] want;
    apply(1, 1, 0, 10'd0, 0, 10'd0, 3'd0, 2'd0, 0, 16'h0);
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      apply($urandom_range(0, 79) == 0, $urandom_range(0, 19) != 0,
            (c % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            10'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, 10'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            16'($urandom));
      n_checks++;
      if (bht_cen !== e_cen || bht_cen_gate !== e_gate || bht_ifu_rd_gnt !== e_gnt || upd_rdy !== e_rdy) begin
        n_fail++; $display("FAIL rnd_ctrl c%0d: cen/gate/gnt/rdy %0b%0b%0b%0b want %0b%0b%0b%0b",
                           c, bht_cen, bht_cen_gate, bht_ifu_rd_gnt, upd_rdy, e_cen, e_gate, e_gnt, e_rdy);
      end
      n_checks++;
      if (bht_ifu_rd_vld !== e_vld || bht_ifu_rd_data !== e_data) begin
        n_fail++; $display("FAIL rnd_read c%0d: vld %0b data %h want %0b %h", c, bht_ifu_rd_vld, bht_ifu_rd_data, e_vld, e_data);
      end
      n_checks++;
      if (bht_wen !== e_wen || (e_cen && bht_idx !== e_idx) || (e_write && bht_din !== e_din)) begin
        n_fail++; $display("FAIL rnd_array c%0d: idx %h din %h wen %h want %h %h %h", c, bht_idx, bht_din, bht_wen, e_idx, e_din, e_wen);
      end
      if (e_chk_empty) begin
        n_checks++;
        if (wbuf_empty !== e_empty) begin n_fail++; $display("FAIL rnd_empty c%0d: got %0b want %0b", c, wbuf_empty, e_empty); end
      end
      if (bht_cen === 1'b1 && bht_wen !== 16'h0) begin
        n_checks++;
        got = {bht_idx, bht_din, bht_wen};
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_sb c%0d: unexpected write %h", c, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin n_fail++; $display("FAIL rnd_sb c%0d: got %h want %h", c, got, want); end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_sb_left: got %0d writes missing want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_saturate();
    test_full();
    test_forward();
    test_disable();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aq_ifu_bht_wbuf.md
AQ_IFU_BHT_WBUF -- requirements
Module: aq_ifu_bht_wbuf

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- forever_cpuclk  in  1  sole clock
- cpurst  in  1  reset, synchronous, active-high
- cp0_ifu_bht_en  in  1  BHT enable
- ifu_bht_rd_req  in  1  prediction read request
- ifu_bht_rd_idx  in  10  read entry index
- bht_ifu_rd_gnt  out  1  read accepted this cycle
- bht_ifu_rd_vld  out  1  read data valid
- bht_ifu_rd_data  out  16  read data, 8 x 2-bit counters
- upd_vld  in  1  branch-resolve update request
- upd_idx  in  10  update entry index
- upd_sel  in  3  counter slot within entry
- upd_cnt  in  2  counter value captured at prediction
- upd_taken  in  1  resolved direction
- upd_rdy  out  1  update accepted when high with upd_vld
- bht_cen, bht_cen_gate  out  1 each  array access enable / ICG enable
- bht_idx  out  10,  bht_din  out  16,  bht_wen  out  16 (per-bit write enable)
- bht_dout  in  16  array read data, one cycle after access
- wbuf_empty  out  1  no pending updates
REQ-002 SHALL use one clock and a synchronous, active-high reset, exactly as listed above.

Function
REQ-003 SHALL buffer updates in a 4-entry in-order FIFO (2-bit pointers plus wrap bit).
REQ-004 upd_rdy SHALL be !full from registered state; an enqueue is never allowed while full, even if a pop occurs in the same cycle.
REQ-005 At enqueue, SHALL store idx, sel and new counter: taken -> min(upd_cnt+1,3); not taken -> max(upd_cnt-1,0).
REQ-006 Arbitration per cycle, priority order:
- (a) full and rd_req -> pop head as write, rd_gnt=0
- (b) rd_req -> read: bht_cen=1, bht_wen=0, bht_idx=rd_idx, rd_gnt=1
- (c) !empty -> pop head as write
- (d) otherwise bht_cen=0
REQ-007 A write SHALL drive bht_idx=head idx, bht_din={8{cnt}}, bht_wen=16'b11<<(2*sel), bht_cen=1, and pop in the same cycle.
REQ-008 Array outputs SHALL be combinational from registered state and inputs.
REQ-009 bht_cen_gate SHALL be (rd_req | !empty) & cp0_ifu_bht_en, a superset of bht_cen.
REQ-010 bht_ifu_rd_vld SHALL assert exactly one cycle after rd_gnt; bht_ifu_rd_data is valid only then and is 16'h0 otherwise.
REQ-011 Same-index updates SHALL remain separate entries and be written in arrival order.
REQ-012 cp0_ifu_bht_en=0:
- upd_rdy=0, rd_gnt=0, bht_cen=0
- FIFO cleared on the next edge
- an in-flight rd_vld still completes

Reset
REQ-013 On cpurst:
- pointers and count 0, entries invalid, wbuf_empty=1
- rd_vld=0, rd_data=0
- bht_cen=bht_cen_gate=0, bht_wen=0, upd_rdy=0 during the reset cycle
REQ-014 Reset asserted mid-operation SHALL drop all pending updates and any in-flight read response.

Configuration
REQ-015 With AQ_IFU_BHT_WBUF_FWD_EN defined:
- the granted rd_idx is registered
- in the rd_vld cycle, every valid FIFO entry matching it overrides its 2-bit slot in bht_dout, applied oldest to youngest (youngest wins)
REQ-016 Without AQ_IFU_BHT_WBUF_FWD_EN, bht_ifu_rd_data SHALL equal bht_dout, with no index register and no compare logic.

Structure
REQ-017 Package aq_ifu_bht_pkg SHALL hold:
- BHT_IDX_W=10, BHT_DATA_W=16, BHT_WBUF_DEPTH=4
- counter encodings SNT=0, WNT=1, WT=2, ST=3
- the FIFO entry struct {idx, sel, cnt}
REQ-018 The FIFO SHALL be a sub-module aq_ifu_bht_wbuf_fifo. Arbitration, counter arithmetic and forwarding SHALL stay in the top.

Verification
REQ-019 Update idx=0x3A, sel=5, cnt=2, taken=1 with no reads -> next cycle bht_cen=1, bht_idx=0x3A, bht_wen=16'h0C00, bht_din=16'hFFFF.
REQ-020 Saturation check:
- cnt=3, taken=1 -> stored 3
- cnt=0, taken=0 -> stored 0 (din=16'h0000)
REQ-021 Five updates while rd_req is held high -> upd_rdy=0 after the fourth; the first full cycle shows a write and rd_gnt=0; the read is granted the following cycle.
REQ-022 With FWD_EN: pending entry idx=7, sel=0, cnt=3, then a read of idx 7 with bht_dout=16'h0000 -> rd_data=16'h0003. Without FWD_EN -> rd_data=16'h0000.
REQ-023 Three updates queued, then cp0_ifu_bht_en=0 for one cycle -> no array writes occur, wbuf_empty=1 next cycle.
REQ-024 cpurst asserted with two entries pending -> wbuf_empty=1 and bht_cen=0 after the edge; no writes occur after reset.
